muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. It is the writer side of the HI/LO register pair held in the decode stage.
- It accepts MULT/MULTU/DIV/DIVU operands from the ID/EX latch and computes over WIDTH cycles.
- On completion it presents HI/LO results with one-cycle HI/LO write strobes toward decode.
- It holds a stall to the pipeline while busy.

Parameters:
- WIDTH, 32: operand/result width; also the iteration count of the multiplier and divider.

Ports:
- clk  input  1  system clock, rising edge
- CLR_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- A  input  WIDTH  rs operand (multiplicand / dividend)
- B  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  synchronous abort; no write produced
- busy  output  1  operation in progress (CALC or DONE)
- stall  output  1  start | busy; freezes IF/ID/EX latches
- done  output  1  one-cycle completion pulse
- HI_out  output  WIDTH  HI result (product high / remainder)
- LO_out  output  WIDTH  LO result (product low / quotient)
- HIWrite  output  1  HI write strobe, equal to done
- LOWrite  output  1  LO write strobe, equal to done

Behaviour:
- Reset (CLR_n=0, asynchronous): state=IDLE, counter=0, busy=0, done=0, HIWrite=0, LOWrite=0, HI_out=0, LO_out=0. Reset mid-operation discards the operation with no write.
- States:
  - IDLE: start=1 → latch op, compute |A| and |B| for signed ops, record sign flags, clear accumulators, counter=0 → CALC. start=0 → stay in IDLE.
  - CALC: one shift-add (multiply) or one restoring-subtract (divide) step per cycle. Counter increments. At counter==WIDTH-1, apply sign fix-up and load HI_out/LO_out → DONE.
  - DONE: done=HIWrite=LOWrite=1 for exactly one cycle → IDLE.
- Latency: start sampled at edge N → done high during cycle N+WIDTH+1. Back-to-back: a new start is accepted in the IDLE cycle after DONE.
- Outputs are registered. HI_out/LO_out are stable for the whole DONE cycle, because decode writes HI/LO on the falling edge. HI_out/LO_out hold their last value after DONE.
- start while busy: ignored. No queueing.
- Multiply:
  - Full 2*WIDTH product; HI = upper half, LO = lower half.
  - MULT: product negated if sign(A) XOR sign(B).
  - MULTU: no sign handling.
- Divide:
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - DIVU: no sign handling.
  - Divide by zero (B==0): LO=all ones, HI=A. Still takes the full latency.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, op=DIV): LO=0x80000000, HI=0.
- flush:
  - Any state → IDLE next edge; done/HIWrite/LOWrite forced 0 in that cycle; HI_out/LO_out unchanged.
  - flush has priority over start in IDLE.
  - flush in the same cycle as DONE suppresses the strobes.
- stall = start | busy, combinational. It is asserted from the cycle start is presented through the DONE cycle inclusive.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: MULT/MULTU bypass CALC. IDLE→DONE directly using a single-cycle full-width multiply, so done is high in cycle N+1. Divide is unchanged.
- Not defined: all four ops use iterative CALC with WIDTH+1 latency. No combinational multiplier is instantiated.

Test Plan:
- Reset during CALC (CLR_n low mid-MULT) → busy=0, done=0, HI_out=LO_out=0 immediately; no strobe ever pulses.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, start at edge 0 → done/HIWrite/LOWrite high only in cycle 33; HI_out=0xFFFFFFFE, LO_out=0x00000001; stall high cycles 0–33.
- MULT A=0xFFFFFFFD (-3), B=7 → HI_out=0xFFFFFFFF, LO_out=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 → LO_out=0xFFFFFFFD (-3), HI_out=0xFFFFFFFF (-1). DIVU A=100, B=7 → LO_out=14, HI_out=2.
- DIVU A=0x12345678, B=0 → LO_out=0xFFFFFFFF, HI_out=0x12345678. DIV A=0x80000000, B=0xFFFFFFFF → LO_out=0x80000000, HI_out=0.
- Second start pulsed during CALC → ignored, single done. flush at cycle 10 of DIV → IDLE next edge, no strobe, HI_out/LO_out keep previous results. With MULDIV_FAST_MUL_EN: MULTU 6×7 → done in cycle 1, LO_out=42, HI_out=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO pair in decode.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle, skipping CALC.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             CLR_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output logic             HIWrite,
  output logic             LOWrite
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_is_div, r_neg_a, r_neg_b;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;

  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic               w_last;
  logic [WIDTH:0]     w_mul_sum, w_rem_shift;
  logic [WIDTH-1:0]   w_mul_hi, w_mul_lo, w_rem_sub, w_div_hi, w_div_lo;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix, w_r_fix, w_res_hi, w_res_lo;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
`endif

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef MULDIV_FAST_MUL_EN
            w_next_state = op[1] ? S_CALC : S_DONE;
`else
            w_next_state = S_CALC;
`endif
          end
        end
        S_CALC:  if (w_last) w_next_state = S_DONE;
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    stall   = start | busy;
    done    = (r_state == S_DONE) & ~flush;
    HIWrite = done;
    LOWrite = done;
  end

  // Signed ops iterate on magnitudes; signs are reapplied on the last step.
  always_comb begin
    w_abs_a     = (~op[0] & A[WIDTH-1]) ? ('0 - A) : A;
    w_abs_b     = (~op[0] & B[WIDTH-1]) ? ('0 - B) : B;
    w_last      = (r_count == CNT_W'(WIDTH - 1));

    w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
    w_mul_hi    = w_mul_sum[WIDTH:1];
    w_mul_lo    = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    w_rem_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_rem_shift >= {1'b0, r_opnd});
    w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_opnd;
    w_div_hi    = w_div_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
    w_div_lo    = {r_lo[WIDTH-2:0], w_div_ge};

    w_prod      = {w_mul_hi, w_mul_lo};
    w_prod_fix  = (r_neg_a ^ r_neg_b) ? ('0 - w_prod) : w_prod;
    // A zero divisor yields an all-ones quotient and the dividend as remainder.
    w_q_fix     = (r_opnd == '0) ? '1 :
                  ((r_neg_a ^ r_neg_b) ? ('0 - w_div_lo) : w_div_lo);
    w_r_fix     = r_neg_a ? ('0 - w_div_hi) : w_div_hi;
    w_res_hi    = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo    = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    if (op[0]) w_fast_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    else       w_fast_prod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  end
`endif

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      HI_out   <= '0;
      LO_out   <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_a  <= ~op[0] & A[WIDTH-1];
            r_neg_b  <= ~op[0] & B[WIDTH-1];
            r_opnd   <= op[1] ? w_abs_b : w_abs_a;
            r_lo     <= op[1] ? w_abs_a : w_abs_b;
            r_hi     <= '0;
            r_count  <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) {HI_out, LO_out} <= w_fast_prod;
`endif
          end
        end
        S_CALC: begin
          r_hi    <= r_is_div ? w_div_hi : w_mul_hi;
          r_lo    <= r_is_div ? w_div_lo : w_mul_lo;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            HI_out <= w_res_hi;
            LO_out <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
